// File: rtl/uart_receiver_fifo.sv
// UART receiver with 16x oversampling, 3-sample majority voting and false-start
// rejection, feeding a first-word-fall-through receive FIFO with valid/ready drain.
module uart_receiver_fifo #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [2:0]                           baud_select,
  input  logic                                 Rx_EN,
  input  logic                                 RxD,
  input  logic                                 Rx_READY,
  output logic [DATA_BITS-1:0]                 Rx_DATA,
  output logic                                 Rx_PERROR,
  output logic                                 Rx_FERROR,
  output logic                                 Rx_VALID,
  output logic                                 Rx_OVERRUN,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  function automatic int calc_div(input int baud);
    return (CLK_FREQ_HZ + baud * 8) / (baud * 16);
  endfunction

  localparam int DW = $clog2(calc_div(300) + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DW-1:0] DIV_TBL [8] = '{
    DW'(calc_div(300)),   DW'(calc_div(1200)),  DW'(calc_div(4800)),  DW'(calc_div(9600)),
    DW'(calc_div(19200)), DW'(calc_div(38400)), DW'(calc_div(57600)), DW'(calc_div(115200))
  };
  localparam logic       ODD      = (PARITY_ODD != 0);
  localparam logic       HAS_PAR  = (PARITY_EN != 0);
  localparam logic       TWO_STOP = (STOP_BITS == 2);
  localparam logic [3:0] NBITS    = 4'(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic                  rx_meta, rx_sync, rx_prev;
  logic [DW-1:0]         div_q, pre;
  logic [3:0]            tcnt;
  logic [1:0]            samp;
  logic [3:0]            bit_cnt;
  logic                  stop_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  perr, ferr;
  logic                  push_vld, push_perr, push_ferr;
  logic [DATA_BITS-1:0]  push_data;
  logic                  tick, maj;

  assign tick = (state != IDLE) && (pre == div_q - 1'b1);
  // samp holds ticks 7 and 8; the live synchronised value is tick 9
  assign maj  = (samp[1] & samp[0]) | (samp[1] & rx_sync) | (samp[0] & rx_sync);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      div_q     <= '0;
      pre       <= '0;
      tcnt      <= '0;
      samp      <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shreg     <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      push_vld  <= 1'b0;
      push_data <= '0;
      push_perr <= 1'b0;
      push_ferr <= 1'b0;
    end else begin
      rx_meta  <= RxD;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      push_vld <= 1'b0;
      if (state != IDLE) pre <= tick ? '0 : pre + 1'b1;
      if (!Rx_EN) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        // a falling edge needs a prior 1, so a held break never restarts a frame
        if (rx_prev && !rx_sync) begin
          state    <= START;
          div_q    <= DIV_TBL[baud_select];
          pre      <= '0;
          tcnt     <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
        end
      end else if (tick) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == 4'd7 || tcnt == 4'd8) samp <= {samp[0], rx_sync};
        if (tcnt == 4'd9) begin
          case (state)
            START:  if (maj) state <= IDLE;
            DATA: begin
              shreg   <= {maj, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
            PARITY: perr <= (maj != ((^shreg) ^ ODD));
            STOP: begin
              if (!maj) ferr <= 1'b1;
              if (stop_cnt == TWO_STOP) begin
                push_vld  <= 1'b1;
                push_data <= shreg;
                push_perr <= perr;
                push_ferr <= ferr | ~maj;
                state     <= IDLE;
              end
            end
            default: ;
          endcase
        end
        if (tcnt == 4'd15) begin
          case (state)
            START:  state <= DATA;
            DATA:   if (bit_cnt == NBITS) state <= HAS_PAR ? PARITY : STOP;
            PARITY: state <= STOP;
            STOP:   stop_cnt <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wp, rp;
  logic [CW-1:0]        count;
  logic                 ovr, pop, full, wr;

  assign Rx_VALID   = (count != '0);
  assign pop        = Rx_VALID && Rx_READY;
  assign full       = (count == CW'(FIFO_DEPTH));
  // a full FIFO still accepts a frame when the head leaves on the same cycle
  assign wr         = push_vld && (!full || pop);
  assign {Rx_DATA, Rx_PERROR, Rx_FERROR} = Rx_VALID ? mem[rp] : '0;
  assign Rx_OVERRUN = ovr;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {push_data, push_perr, push_ferr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovr   <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
      if (!Rx_EN)                        ovr <= 1'b0;
      else if (push_vld && full && !pop) ovr <= 1'b1;
    end
  end

endmodule
